// File: rtl/scan_pkg.sv
// Shared types for the result frame scanner: FSM states and the FIFO beat layout.
package scan_pkg;

    localparam int SCAN_PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [SCAN_PIX_W-1:0] pix;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } pix_beat_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Small sync FIFO of pixel beats; head is read straight from storage flops, 1-cycle push-to-visible latency.
// Push when full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module pixel_skid_fifo
    import scan_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  pix_beat_t     pushDat,
    input  logic          pop,
    output pix_beat_t     popDat,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pix_beat_t         mem [DEPTH];
    logic     [PW-1:0] wrPtr;
    logic     [PW-1:0] rdPtr;
    logic              doPush;
    logic              doPop;

    assign doPop  = pop && (count != '0);
    assign doPush = push && ((count != CW'(DEPTH)) || doPop);
    assign popDat = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushDat;
                wrPtr      <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_frame_scanner.sv
// Raster-scans the result image out of data RAM after f_done rises; first pixel 2 cycles after busy.
// Reads are credit-limited to FIFO space, so consumer stalls simply pause the scan with no loss.
module result_frame_scanner
    import scan_pkg::*;
#(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int PIX_W      = SCAN_PIX_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [JW-1:0] LAST_J = JW'(WIDTH - 1);
    localparam logic [IW-1:0] LAST_I = IW'(HEIGHT - 1);

    scan_state_t       state;
    scan_state_t       stateNxt;
    logic              fDoneQ;
    logic [JW-1:0]     colJ;
    logic [IW-1:0]     rowI;
    logic [ADDR_W-1:0] addrQ;
    logic              rdEn;
    logic              rdInflight;
    logic              tagSof;
    logic              tagEol;
    logic              tagEof;
    logic              popHs;
    logic              lastRead;
    logic [CW:0]       credUsed;
    logic [CW-1:0]     fifoCount;
    pix_beat_t         pushDat;
    pix_beat_t         headDat;
    logic              unusedRamBits;

    assign unusedRamBits = ^ram_data[DATA_W-1:PIX_W];

    // Entries committed = stored beats + the read still in the RAM, minus the beat leaving now.
    assign popHs    = pix_valid && pix_ready;
    assign credUsed = {1'b0, fifoCount} + {{CW{1'b0}}, rdInflight} - {{CW{1'b0}}, popHs};
    assign rdEn     = (state == SCAN) && (credUsed < (CW+1)'(FIFO_DEPTH));
    assign lastRead = rdEn && (rowI == LAST_I) && (colJ == LAST_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            fDoneQ <= 1'b0;
        end else begin
            state  <= stateNxt;
            fDoneQ <= f_done;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:  if (f_done && !fDoneQ) stateNxt = SCAN;
            SCAN:  if (lastRead) stateNxt = DRAIN;
            DRAIN: if (popHs && headDat.eof && (fifoCount == CW'(1)) && !rdInflight) stateNxt = DONE;
            DONE:  if (!f_done) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colJ  <= '0;
            rowI  <= '0;
            addrQ <= '0;
        end else if (state == IDLE) begin
            colJ  <= '0;
            rowI  <= '0;
            addrQ <= '0;
        end else if (rdEn) begin
            addrQ <= addrQ + 1'b1;
            if (colJ == LAST_J) begin
                colJ <= '0;
                rowI <= rowI + 1'b1;
            end else begin
                colJ <= colJ + 1'b1;
            end
        end
    end

    // Position tags ride one stage behind the read so they meet the returning RAM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdInflight <= 1'b0;
            tagSof     <= 1'b0;
            tagEol     <= 1'b0;
            tagEof     <= 1'b0;
        end else begin
            rdInflight <= rdEn;
            if (rdEn) begin
                tagSof <= (rowI == '0) && (colJ == '0);
                tagEol <= (colJ == LAST_J);
                tagEof <= (rowI == LAST_I) && (colJ == LAST_J);
            end
        end
    end

    assign pushDat.pix = ram_data[PIX_W-1:0];
    assign pushDat.sof = tagSof;
    assign pushDat.eol = tagEol;
    assign pushDat.eof = tagEof;

    pixel_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rdInflight),
        .pushDat (pushDat),
        .pop     (popHs),
        .popDat  (headDat),
        .count   (fifoCount)
    );

    assign ram_rd_en  = rdEn;
    assign ram_addr   = addrQ;
    assign pix_valid  = (fifoCount != '0);
    assign pix_data   = headDat.pix;
    assign pix_sof    = headDat.sof;
    assign pix_eol    = headDat.eol;
    assign pix_eof    = headDat.eof;
    assign busy       = (state == SCAN) || (state == DRAIN);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_result_frame_scanner.sv
// Bench for result_frame_scanner on a 4x3 frame with RAM word k = k+16.
module tb_result_frame_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_done;
    logic        pix_ready;
    logic        ram_rd_en;
    logic [13:0] ram_addr;
    logic [31:0] ram_data;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic        busy;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [10:0] beatQ[$];
    int          beatCyc[$];
    logic [13:0] addrQ[$];
    int          addrCyc[$];
    int          busyRise, firstValid, doneCyc, stallViol, creditViol, readsAt20;

    result_frame_scanner #(
        .WIDTH      (4),
        .HEIGHT     (3),
        .ADDR_W     (14),
        .DATA_W     (32),
        .PIX_W      (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_done     (f_done),
        .ram_rd_en  (ram_rd_en),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial ram_data = 32'd0;
    always @(posedge clk) if (ram_rd_en) ram_data <= 32'(ram_addr) + 32'd16;

    // Reference beat k of the raster: {sof, eol, eof, pixel}.
    function automatic logic [10:0] exp_beat(input int k);
        logic [7:0] d;
        d = 8'(16 + k);
        return {(k == 0), ((k % 4) == 3), (k == 11), d};
    endfunction

    // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random, 3 stalled for 20 cycles
    task automatic run_frame(input int mode, input bit pulse);
        int          outstanding;
        bit          hold;
        logic [10:0] hDat;
        logic        pop;
        f_done = 1'b0;
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        beatQ.delete(); beatCyc.delete(); addrQ.delete(); addrCyc.delete();
        busyRise = -1; firstValid = -1; doneCyc = -1;
        stallViol = 0; creditViol = 0; readsAt20 = -1;
        outstanding = 0; hold = 1'b0; hDat = '0;
        for (int c = 0; c < 400 && doneCyc < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) f_done = 1'b1;
            if (c == 1 && pulse) f_done = 1'b0;
            case (mode)
                1:       pix_ready = ((c % 4) == 0) || ((c % 4) == 3);
                2:       pix_ready = 1'($urandom_range(0, 1));
                3:       pix_ready = (c >= 20);
                default: pix_ready = 1'b1;
            endcase
            @(negedge clk);
            if (busy && busyRise < 0) busyRise = c;
            if (pix_valid && firstValid < 0) firstValid = c;
            if (frame_done) doneCyc = c;
            if (hold && (!pix_valid || {pix_sof, pix_eol, pix_eof, pix_data} != hDat)) stallViol++;
            hold = pix_valid && !pix_ready;
            hDat = {pix_sof, pix_eol, pix_eof, pix_data};
            pop  = pix_valid && pix_ready;
            if (ram_rd_en) begin
                if (outstanding - int'(pop) >= 2) creditViol++;
                addrQ.push_back(ram_addr);
                addrCyc.push_back(c);
                outstanding++;
            end
            if (pop) begin
                beatQ.push_back(hDat);
                beatCyc.push_back(c);
                outstanding--;
            end
            if (c == 19) readsAt20 = addrQ.size();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_done = 1'b0; pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ram_rd_en, ram_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, frame_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got rd=%b addr=%0d vld=%b dat=%0d busy=%b done=%b want all 0",
                     ram_rd_en, ram_addr, pix_valid, pix_data, busy, frame_done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ram_rd_en, busy, pix_valid, frame_done} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got rd=%b busy=%b vld=%b done=%b want 0", ram_rd_en, busy, pix_valid, frame_done);
        end
    endtask

    task automatic test_full_rate();
        run_frame(0, 1'b0);
        vectors++;
        if (beatQ.size() != 12) begin miscompares++; $display("FAIL full_beats got %0d want 12", beatQ.size()); end
        for (int k = 0; k < beatQ.size() && k < 12; k++) begin
            vectors++;
            if (beatQ[k] !== exp_beat(k) || beatCyc[k] != beatCyc[0] + k) begin
                miscompares++;
                $display("FAIL full_beat%0d got %h@%0d want %h@%0d", k, beatQ[k], beatCyc[k], exp_beat(k), beatCyc[0] + k);
            end
        end
        vectors++;
        if (addrQ.size() != 12) begin miscompares++; $display("FAIL full_reads got %0d want 12", addrQ.size()); end
        for (int k = 0; k < addrQ.size() && k < 12; k++) begin
            vectors++;
            if (addrQ[k] !== 14'(k) || addrCyc[k] != addrCyc[0] + k) begin
                miscompares++;
                $display("FAIL full_addr%0d got %0d@%0d want %0d@%0d", k, addrQ[k], addrCyc[k], k, addrCyc[0] + k);
            end
        end
        vectors++;
        if (busyRise < 0 || firstValid - busyRise != 2) begin
            miscompares++;
            $display("FAIL first_latency got %0d want 2", firstValid - busyRise);
        end
        vectors++;
        if (beatCyc.size() == 0 || doneCyc != beatCyc[beatCyc.size() - 1] + 1) begin
            miscompares++;
            $display("FAIL frame_done_cycle got %0d want one after last beat", doneCyc);
        end
        vectors++;
        if (creditViol != 0) begin miscompares++; $display("FAIL full_credit got %0d violations want 0", creditViol); end
    endtask

    task automatic test_held_fdone();
        int bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ram_rd_en || busy || !frame_done) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL held_no_rescan got %0d bad cycles want 0", bad); end
        f_done = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_idle got done=%b busy=%b want 0 0", frame_done, busy);
        end
        run_frame(0, 1'b0);
        vectors++;
        if (beatQ.size() != 12 || doneCyc < 0) begin
            miscompares++;
            $display("FAIL second_frame got %0d beats done=%0d want 12 beats", beatQ.size(), doneCyc);
        end
        for (int k = 0; k < beatQ.size() && k < 12; k++) begin
            vectors++;
            if (beatQ[k] !== exp_beat(k)) begin
                miscompares++;
                $display("FAIL second_beat%0d got %h want %h", k, beatQ[k], exp_beat(k));
            end
        end
    endtask

    task automatic test_backpressure(input int mode, input string name);
        run_frame(mode, 1'b0);
        vectors++;
        if (beatQ.size() != 12 || doneCyc < 0) begin
            miscompares++;
            $display("FAIL %s_beats got %0d done=%0d want 12 beats", name, beatQ.size(), doneCyc);
        end
        for (int k = 0; k < beatQ.size() && k < 12; k++) begin
            vectors++;
            if (beatQ[k] !== exp_beat(k)) begin
                miscompares++;
                $display("FAIL %s_beat%0d got %h want %h", name, k, beatQ[k], exp_beat(k));
            end
        end
        vectors++;
        if (stallViol != 0) begin miscompares++; $display("FAIL %s_stable got %0d changes want 0", name, stallViol); end
        vectors++;
        if (creditViol != 0) begin miscompares++; $display("FAIL %s_credit got %0d violations want 0", name, creditViol); end
        if (mode == 3) begin
            vectors++;
            if (readsAt20 != 2) begin miscompares++; $display("FAIL stall_reads got %0d want 2", readsAt20); end
        end
    endtask

    task automatic test_reset_mid();
        bool_found: begin end
        f_done = 1'b0; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 f_done = 1'b1;
        begin
            bit found = 1'b0;
            for (int c = 0; c < 50 && !found; c++) begin
                @(negedge clk);
                if (pix_valid && pix_ready && pix_data == 8'd21) found = 1'b1;
            end
            vectors++;
            if (!found) begin miscompares++; $display("FAIL mid_beat5 got not seen want seen"); end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({ram_rd_en, ram_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, frame_done} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got rd=%b addr=%0d vld=%b dat=%0d busy=%b want all 0",
                     ram_rd_en, ram_addr, pix_valid, pix_data, busy);
        end
        f_done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(0, 1'b0);
        vectors++;
        if (addrQ.size() == 0 || addrQ[0] !== 14'd0) begin
            miscompares++;
            $display("FAIL restart_addr got %0d want 0", (addrQ.size() != 0) ? int'(addrQ[0]) : -1);
        end
        vectors++;
        if (beatQ.size() != 12) begin miscompares++; $display("FAIL restart_beats got %0d want 12", beatQ.size()); end
        for (int k = 0; k < beatQ.size() && k < 12; k++) begin
            vectors++;
            if (beatQ[k] !== exp_beat(k)) begin
                miscompares++;
                $display("FAIL restart_beat%0d got %h want %h", k, beatQ[k], exp_beat(k));
            end
        end
    endtask

    task automatic test_pulse();
        run_frame(0, 1'b1);
        vectors++;
        if (beatQ.size() != 12 || doneCyc < 0) begin
            miscompares++;
            $display("FAIL pulse_beats got %0d done=%0d want 12 beats", beatQ.size(), doneCyc);
        end
        for (int k = 0; k < beatQ.size() && k < 12; k++) begin
            vectors++;
            if (beatQ[k] !== exp_beat(k)) begin
                miscompares++;
                $display("FAIL pulse_beat%0d got %h want %h", k, beatQ[k], exp_beat(k));
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_idle got done=%b busy=%b want 0 0", frame_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_held_fdone();
        test_backpressure(1, "toggle");
        test_backpressure(3, "stall");
        test_backpressure(2, "random");
        test_backpressure(2, "random2");
        test_reset_mid();
        test_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
